// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon AD absorption sequencer.
package ascon_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        AD_IDLE  = 3'd0,
        AD_LOAD  = 3'd1,
        AD_ISSUE = 3'd2,
        AD_WAIT  = 3'd3,
        AD_DONE  = 3'd4,
        AD_ERR   = 3'd5
    } ad_state_e;

    // Absorption rate in bytes per block
    localparam int unsigned RATE_128  = 8;
    localparam int unsigned RATE_128A = 16;

    // sel_type encodings
    localparam logic [1:0] SEL_128  = 2'd0;
    localparam logic [1:0] SEL_128A = 2'd1;

    // 320-bit Ascon permutation state, x0 in the most significant word
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    function automatic logic sel_legal(input logic [1:0] sel);
        return (sel == SEL_128) || (sel == SEL_128A);
    endfunction

endpackage

// File: rtl/ascon_ad_wait_cnt.sv
// Datapath latency timer: down-counter loaded with DP_LATENCY at issue,
// flags the cycle in which the datapath result is valid.
module ascon_ad_wait_cnt #(
    parameter int unsigned DP_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int unsigned CNT_W = (DP_LATENCY < 2) ? 1 : $clog2(DP_LATENCY + 1);

    logic [CNT_W-1:0] cnt;

    // Load on issue, count down while waiting, stop at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(DP_LATENCY);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/ascon_ad_sequencer.sv
// Ascon associated-data absorption sequencer: feeds AD words block by block
// through the external ascon_AE_AM datapath and returns the absorbed state.
// Optional build macro: ASCON_AD_PERF_CNT_EN adds blk_cnt / cyc_cnt outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// AD_IDLE  | after reset, waiting for start
// AD_LOAD  | ad_ready high, waiting for the next AD word
// AD_ISSUE | one-cycle dp_process_en pulse for the latched word
// AD_WAIT  | waiting DP_LATENCY cycles for the datapath result
// AD_DONE  | final state on x*_o, done pulsed on entry
// AD_ERR   | datapath error or illegal sel_type, err held until start
module ascon_ad_sequencer
    import ascon_pkg::*;
#(
    parameter int unsigned DP_LATENCY = 1,
    parameter int unsigned LEN_W      = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       sel_type,
    input  logic [LEN_W-1:0] ad_length,
    input  logic [63:0]      x0_init,
    input  logic [63:0]      x1_init,
    input  logic [63:0]      x2_init,
    input  logic [63:0]      x3_init,
    input  logic [63:0]      x4_init,
    input  logic             ad_valid,
    input  logic [127:0]     ad_data,
    output logic             ad_ready,
    output logic             dp_process_en,
    output logic [1:0]       dp_sel_type,
    output logic [LEN_W-1:0] dp_data_length,
    output logic [LEN_W-1:0] dp_data_position,
    output logic [127:0]     dp_data,
    output logic [63:0]      dp_x0_i,
    output logic [63:0]      dp_x1_i,
    output logic [63:0]      dp_x2_i,
    output logic [63:0]      dp_x3_i,
    output logic [63:0]      dp_x4_i,
    input  logic [63:0]      dp_x0_o,
    input  logic [63:0]      dp_x1_o,
    input  logic [63:0]      dp_x2_o,
    input  logic [63:0]      dp_x3_o,
    input  logic [63:0]      dp_x4_o,
    input  logic             dp_process_err,
    output logic [63:0]      x0_o,
    output logic [63:0]      x1_o,
    output logic [63:0]      x2_o,
    output logic [63:0]      x3_o,
    output logic [63:0]      x4_o,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef ASCON_AD_PERF_CNT_EN
    ,
    output logic [31:0]      blk_cnt,
    output logic [31:0]      cyc_cnt
`endif
);

    ad_state_e        state;
    logic [1:0]       sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] pos_q;
    logic [127:0]     word_q;
    ascon_state_t     st_q;
    ascon_state_t     out_q;
    ascon_state_t     dp_res;
    ascon_state_t     init_st;
    logic             done_q;
    logic             wait_last;
    logic             capture;
    logic             idle_like;
    logic [LEN_W:0]   rate_ext;
    logic [LEN_W:0]   pos_next;

    assign init_st = {x0_init, x1_init, x2_init, x3_init, x4_init};
    assign dp_res  = {dp_x0_o, dp_x1_o, dp_x2_o, dp_x3_o, dp_x4_o};

    // One extra bit so position + rate never wraps before the length compare
    assign rate_ext = (sel_q == SEL_128A) ? (LEN_W+1)'(RATE_128A) : (LEN_W+1)'(RATE_128);
    assign pos_next = {1'b0, pos_q} + rate_ext;

    assign idle_like = (state == AD_IDLE) || (state == AD_DONE) || (state == AD_ERR);
    assign capture   = (DP_LATENCY == 0) ? (state == AD_ISSUE)
                                         : ((state == AD_WAIT) && wait_last);

    ascon_ad_wait_cnt #(
        .DP_LATENCY (DP_LATENCY)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (state == AD_ISSUE),
        .en   (state == AD_WAIT),
        .last (wait_last)
    );

    // Message sequencing: latch on start, absorb blocks, report result
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= AD_IDLE;
            sel_q  <= '0;
            len_q  <= '0;
            pos_q  <= '0;
            word_q <= '0;
            st_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                AD_IDLE, AD_DONE, AD_ERR: begin
                    if (start) begin
                        sel_q  <= sel_type;
                        len_q  <= ad_length;
                        st_q   <= init_st;
                        pos_q  <= '0;
                        word_q <= '0;
                        out_q  <= '0;
                        if (!sel_legal(sel_type)) begin
                            state <= AD_ERR;
                        end else if (ad_length == '0) begin
                            out_q  <= init_st;
                            done_q <= 1'b1;
                            state  <= AD_DONE;
                        end else begin
                            state <= AD_LOAD;
                        end
                    end
                end
                AD_LOAD: begin
                    if (ad_valid) begin
                        // Upper half is outside the 8-byte rate and must not reach the datapath
                        word_q <= (sel_q == SEL_128A) ? ad_data : {64'b0, ad_data[63:0]};
                        state  <= AD_ISSUE;
                    end
                end
                AD_ISSUE, AD_WAIT: begin
                    if ((state == AD_ISSUE) && (DP_LATENCY != 0)) begin
                        state <= AD_WAIT;
                    end
                    if (capture) begin
                        if (dp_process_err) begin
                            state <= AD_ERR;
                        end else begin
                            st_q  <= dp_res;
                            pos_q <= pos_next[LEN_W-1:0];
                            if (pos_next >= {1'b0, len_q}) begin
                                out_q  <= dp_res;
                                done_q <= 1'b1;
                                state  <= AD_DONE;
                            end else begin
                                state <= AD_LOAD;
                            end
                        end
                    end
                end
                default: state <= AD_IDLE;
            endcase
        end
    end

`ifdef ASCON_AD_PERF_CNT_EN
    // Block and cycle counters; cleared on start, frozen outside a message
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
            cyc_cnt <= '0;
        end else if (idle_like && start) begin
            blk_cnt <= '0;
            cyc_cnt <= '0;
        end else begin
            if (busy) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (capture && !dp_process_err) begin
                blk_cnt <= blk_cnt + 32'd1;
            end
        end
    end
`endif

    assign ad_ready         = (state == AD_LOAD);
    assign dp_process_en    = (state == AD_ISSUE);
    assign busy             = (state == AD_LOAD) || (state == AD_ISSUE) || (state == AD_WAIT);
    assign err              = (state == AD_ERR);
    assign done             = done_q;
    assign dp_sel_type      = sel_q;
    assign dp_data_length   = len_q;
    assign dp_data_position = pos_q;
    assign dp_data          = word_q;
    assign dp_x0_i          = st_q.x0;
    assign dp_x1_i          = st_q.x1;
    assign dp_x2_i          = st_q.x2;
    assign dp_x3_i          = st_q.x3;
    assign dp_x4_i          = st_q.x4;
    assign x0_o             = out_q.x0;
    assign x1_o             = out_q.x1;
    assign x2_o             = out_q.x2;
    assign x3_o             = out_q.x3;
    assign x4_o             = out_q.x4;

endmodule

// File: tb/tb_ascon_ad_sequencer.sv
// Testbench for ascon_ad_sequencer with a behavioural one-cycle datapath.
module tb_ascon_ad_sequencer;

    typedef logic [4:0][63:0] st_t;

    typedef struct {
        logic [32:0]  pos;
        logic [127:0] data;
        st_t          xi;
        logic [32:0]  len;
        logic [1:0]   sel;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   sel_type = '0;
    logic [32:0]  ad_length = '0;
    st_t          drv_init = '0;
    logic         ad_valid = 1'b0;
    logic [127:0] ad_data = '0;
    logic         ad_ready;
    logic         dp_process_en;
    logic [1:0]   dp_sel_type;
    logic [32:0]  dp_data_length;
    logic [32:0]  dp_data_position;
    logic [127:0] dp_data;
    logic [63:0]  dpi0, dpi1, dpi2, dpi3, dpi4;
    st_t          dp_o = '0;
    logic         dp_err = 1'b0;
    logic [63:0]  xo0, xo1, xo2, xo3, xo4;
    logic         busy, done, err;
    st_t          dpi, xo;

    int           errors = 0;
    int           checks = 0;
    exp_t         exp_q[$];
    st_t          init_st;
    st_t          exp_final;
    st_t          res_62;
    logic [127:0] word_mem [8];
    int           issue_cnt = 0;
    int           err_at_blk = -1;

    assign dpi = {dpi4, dpi3, dpi2, dpi1, dpi0};
    assign xo  = {xo4, xo3, xo2, xo1, xo0};

    always #5 clk = ~clk;

    ascon_ad_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .sel_type         (sel_type),
        .ad_length        (ad_length),
        .x0_init          (drv_init[0]),
        .x1_init          (drv_init[1]),
        .x2_init          (drv_init[2]),
        .x3_init          (drv_init[3]),
        .x4_init          (drv_init[4]),
        .ad_valid         (ad_valid),
        .ad_data          (ad_data),
        .ad_ready         (ad_ready),
        .dp_process_en    (dp_process_en),
        .dp_sel_type      (dp_sel_type),
        .dp_data_length   (dp_data_length),
        .dp_data_position (dp_data_position),
        .dp_data          (dp_data),
        .dp_x0_i          (dpi0),
        .dp_x1_i          (dpi1),
        .dp_x2_i          (dpi2),
        .dp_x3_i          (dpi3),
        .dp_x4_i          (dpi4),
        .dp_x0_o          (dp_o[0]),
        .dp_x1_o          (dp_o[1]),
        .dp_x2_o          (dp_o[2]),
        .dp_x3_o          (dp_o[3]),
        .dp_x4_o          (dp_o[4]),
        .dp_process_err   (dp_err),
        .x0_o             (xo0),
        .x1_o             (xo1),
        .x2_o             (xo2),
        .x3_o             (xo3),
        .x4_o             (xo4),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    // Arbitrary but position/data sensitive mixing function standing in for ascon_AE_AM
    function automatic st_t dp_f(input st_t s, input logic [127:0] d, input logic [32:0] p);
        st_t r;
        r[0] = s[0] ^ d[63:0];
        r[1] = s[1] ^ d[127:64];
        r[2] = s[2] + {31'b0, p};
        r[3] = {s[3][62:0], s[3][63]} ^ s[0];
        r[4] = s[4] ^ s[1] ^ 64'h5a5a_0f0f_3c3c_9696;
        return r;
    endfunction

    // Datapath model with one cycle of latency and an injectable error
    always @(posedge clk) begin
        if (dp_process_en) begin
            dp_o   <= dp_f(dpi, dp_data, dp_data_position);
            dp_err <= (issue_cnt == err_at_blk);
            issue_cnt = issue_cnt + 1;
        end
    end

    // Scoreboard: every datapath issue is matched against the next expected block
    always @(negedge clk) begin
        if (dp_process_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue pos=%0d", dp_data_position);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (dp_data_position !== e.pos) begin
                    errors++;
                    $display("FAIL issue_pos got=%0d exp=%0d", dp_data_position, e.pos);
                end
                checks++;
                if (dp_data !== e.data) begin
                    errors++;
                    $display("FAIL issue_data got=%h exp=%h", dp_data, e.data);
                end
                checks++;
                if (dpi !== e.xi) begin
                    errors++;
                    $display("FAIL issue_state got=%h exp=%h", dpi, e.xi);
                end
                checks++;
                if (dp_data_length !== e.len || dp_sel_type !== e.sel) begin
                    errors++;
                    $display("FAIL issue_cfg got len=%0d sel=%0d exp len=%0d sel=%0d",
                             dp_data_length, dp_sel_type, e.len, e.sel);
                end
            end
        end
    end

    // Starts a message, queues the expected blocks, and sends nsend words
    task automatic drive_msg(input logic [1:0] sel, input logic [32:0] len, input int nsend,
                             input int stall_at, input int stall_cyc, input int poke_at);
        int rate, nblk, n;
        logic acc;
        st_t m;
        exp_t e;
        rate = (sel == 2'd1) ? 16 : 8;
        nblk = (int'(len) + rate - 1) / rate;
        m = init_st;
        for (int b = 0; b < nblk; b++) begin
            e.pos  = 33'(b * rate);
            e.data = (rate == 16) ? word_mem[b] : {64'b0, word_mem[b][63:0]};
            e.xi   = m;
            e.len  = len;
            e.sel  = sel;
            exp_q.push_back(e);
            m = dp_f(m, e.data, e.pos);
        end
        exp_final = m;
        issue_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; sel_type = sel; ad_length = len; drv_init = init_st;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < nsend; b++) begin
            if (b == stall_at) begin
                ad_valid = 1'b0;
                n = 0;
                @(negedge clk);
                while (ad_ready !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int s = 0; s < stall_cyc; s++) begin
                    checks++;
                    if (ad_ready !== 1'b1 || dp_process_en !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_cycle%0d ready=%b en=%b exp ready=1 en=0",
                                 s, ad_ready, dp_process_en);
                    end
                    if (s < stall_cyc - 1) @(negedge clk);
                end
                @(posedge clk); #1;
            end
            ad_valid = 1'b1;
            ad_data  = word_mem[b];
            if (b == poke_at) begin
                start = 1'b1; sel_type = 2'd0; ad_length = 33'd5;
            end
            n = 0;
            acc = 1'b0;
            while (!acc && n < 50) begin
                @(negedge clk);
                acc = (ad_ready === 1'b1);
                @(posedge clk); #1;
                start = 1'b0; sel_type = sel; ad_length = len;
                n++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout word=%0d got=no_ready exp=ready", b);
                ad_valid = 1'b0;
                return;
            end
        end
        ad_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, ad_ready, dp_process_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000", {busy, done, err, ad_ready, dp_process_en});
        end
        checks++;
        if (xo !== '0 || dpi !== '0) begin
            errors++;
            $display("FAIL reset_state got xo=%h dpi=%h exp=0", xo, dpi);
        end
        checks++;
        if (dp_data !== '0 || dp_data_position !== '0 || dp_data_length !== '0 || dp_sel_type !== '0) begin
            errors++;
            $display("FAIL reset_dp got data=%h pos=%0d len=%0d sel=%0d exp=0",
                     dp_data, dp_data_position, dp_data_length, dp_sel_type);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_rate16_62();
        int n;
        drive_msg(2'd1, 33'd62, 4, -1, 0, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL r16_done_latency got=%0d exp=3", n);
        end
        checks++;
        if (xo !== exp_final) begin
            errors++;
            $display("FAIL r16_result got=%h exp=%h", xo, exp_final);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || exp_q.size() != 0 || dp_data_length !== 33'd62) begin
            errors++;
            $display("FAIL r16_end got busy=%b err=%b pending=%0d len=%0d exp busy=0 err=0 pending=0 len=62",
                     busy, err, exp_q.size(), dp_data_length);
        end
        res_62 = exp_final;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || xo !== exp_final) begin
            errors++;
            $display("FAIL r16_done_pulse got done=%b exp done=0 with held result", done);
        end
    endtask

    task automatic test_rate8_20();
        int n;
        drive_msg(2'd0, 33'd20, 3, -1, 0, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        checks++;
        if (done !== 1'b1 || xo !== exp_final) begin
            errors++;
            $display("FAIL r8_result got done=%b xo=%h exp done=1 xo=%h", done, xo, exp_final);
        end
        checks++;
        if (exp_q.size() != 0 || dp_data[127:64] !== 64'b0) begin
            errors++;
            $display("FAIL r8_blocks got pending=%0d upper=%h exp pending=0 upper=0",
                     exp_q.size(), dp_data[127:64]);
        end
    endtask

    task automatic test_zero_len();
        init_st = {$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b1; sel_type = 2'd1; ad_length = 33'd0; drv_init = init_st;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || xo !== init_st) begin
            errors++;
            $display("FAIL zero_len got done=%b xo=%h exp done=1 xo=%h", done, xo, init_st);
        end
        checks++;
        if (ad_ready !== 1'b0 || dp_process_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_idle got ready=%b en=%b busy=%b exp=000", ad_ready, dp_process_en, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_stall();
        int n;
        init_st = {64'h0123_4567_89ab_cdef, 64'h1111_2222_3333_4444, 64'hdead_beef_0000_0001,
                   64'h8000_0000_0000_0003, 64'hfeed_face_cafe_f00d};
        drive_msg(2'd1, 33'd62, 4, 1, 10, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        checks++;
        if (done !== 1'b1 || xo !== res_62) begin
            errors++;
            $display("FAIL stall_result got done=%b xo=%h exp done=1 xo=%h", done, xo, res_62);
        end
    endtask

    task automatic test_dp_error();
        int n;
        logic saw_done;
        err_at_blk = 1;
        drive_msg(2'd1, 33'd62, 2, -1, 0, -1);
        n = 0;
        saw_done = 1'b0;
        do begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            n++;
        end while (err !== 1'b1 && n < 20);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || ad_ready !== 1'b0 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL dp_err got err=%b busy=%b ready=%b done_seen=%b exp 1 0 0 0",
                     err, busy, ad_ready, saw_done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL dp_err_sticky got err=%b done=%b exp err=1 done=0", err, done);
        end
        exp_q.delete();
        err_at_blk = -1;
        @(posedge clk); #1;
        start = 1'b1; sel_type = 2'd2; ad_length = 33'd10;
        @(posedge clk); #1;
        start = 1'b0; sel_type = 2'd0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_sel got err=%b busy=%b exp err=1 busy=0", err, busy);
        end
        drive_msg(2'd0, 33'd20, 3, -1, 0, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || xo !== exp_final) begin
            errors++;
            $display("FAIL err_recover got done=%b err=%b xo=%h exp done=1 err=0 xo=%h",
                     done, err, xo, exp_final);
        end
    endtask

    task automatic test_rst_mid();
        drive_msg(2'd1, 33'd62, 3, -1, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dp_process_en !== 1'b0 || dp_data_position !== 33'd32) begin
            errors++;
            $display("FAIL rst_wait_state got busy=%b en=%b pos=%0d exp busy=1 en=0 pos=32",
                     busy, dp_process_en, dp_data_position);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({busy, done, err, ad_ready, dp_process_en} !== 5'b0 || xo !== '0 || dpi !== '0) begin
            errors++;
            $display("FAIL rst_mid_flags got flags=%b xo=%h dpi=%h exp all 0",
                     {busy, done, err, ad_ready, dp_process_en}, xo, dpi);
        end
        checks++;
        if (dp_data !== '0 || dp_data_position !== '0 || dp_data_length !== '0 || dp_sel_type !== '0) begin
            errors++;
            $display("FAIL rst_mid_dp got data=%h pos=%0d len=%0d sel=%0d exp 0",
                     dp_data, dp_data_position, dp_data_length, dp_sel_type);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            word_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        init_st = {64'h0123_4567_89ab_cdef, 64'h1111_2222_3333_4444, 64'hdead_beef_0000_0001,
                   64'h8000_0000_0000_0003, 64'hfeed_face_cafe_f00d};
        test_reset();
        test_rate16_62();
        test_rate8_20();
        test_zero_len();
        test_stall();
        test_dp_error();
        test_rst_mid();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascon_ad_sequencer.md
Name: ascon_ad_sequencer

Overview:
Controller that sequences the associated-data absorption datapath (ascon_AE_AM) over a complete AD message. It accepts the post-initialization state and a stream of 128-bit AD words through a valid/ready handshake. For each block it drives the datapath's process_en, data_length, data_position, data and state inputs, then feeds the datapath's output state back in. It sits between ascon_initialization and the plaintext/ciphertext stage and reports the final absorbed state with a done pulse.

Parameters:
DP_LATENCY, 1, cycles from dp_process_en asserted to valid dp_x*_o (0 means combinational datapath)
LEN_W, 33, width of ad_length, dp_data_length and dp_data_position

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  begin a message; sampled only in IDLE/DONE/ERR
sel_type  input  2  1 = Ascon-128a (16-byte rate); 0 = Ascon-128 (8-byte rate); others illegal
ad_length  input  LEN_W  AD length in bytes, latched on start
x0_init..x4_init  input  64 each  initialized state, latched on start
ad_valid  input  1  AD word available
ad_data  input  128  AD word, little-endian byte order (byte 0 = bits 7:0)
ad_ready  output  1  sequencer accepts ad_data
dp_process_en  output  1  datapath enable
dp_sel_type  output  2  latched sel_type
dp_data_length  output  LEN_W  latched ad_length
dp_data_position  output  LEN_W  byte offset of current block
dp_data  output  128  current AD word; bits 127:64 forced 0 when rate = 8
dp_x0_i..dp_x4_i  output  64 each  current state to datapath
dp_x0_o..dp_x4_o  input  64 each  datapath result state
dp_process_err  input  1  datapath error flag
x0_o..x4_o  output  64 each  final absorbed state
busy  output  1  message in progress
done  output  1  one-cycle pulse, final state valid
err  output  1  sticky error

Behaviour:
- Reset: state = IDLE; all outputs 0; internal state registers 0; position 0.
- States: IDLE, LOAD, ISSUE, WAIT, DONE, ERR.
- IDLE/DONE/ERR + start: latch sel_type, ad_length, x*_init; clear position and err.
  - sel_type not in {0,1} -> ERR.
  - ad_length == 0 -> DONE with x*_o = x*_init; done pulses next cycle; no datapath activity.
  - otherwise -> LOAD.
- LOAD: ad_ready = 1. On ad_valid & ad_ready, latch the word and go to ISSUE. ad_valid low stalls indefinitely.
- ISSUE: dp_process_en = 1 for exactly one cycle, with dp_data_position = position and dp_x*_i = state registers.
  - DP_LATENCY = 0: capture dp_x*_o in this cycle.
  - DP_LATENCY > 0: go to WAIT and count DP_LATENCY cycles, capturing in the last one. dp_process_en = 0 during WAIT.
- Capture:
  - dp_process_err = 1 -> ERR.
  - Otherwise state registers <= dp_x*_o and position += rate.
  - If the new position >= ad_length -> DONE, else -> LOAD.
  - The compare uses LEN_W+1 bits so the position add cannot wrap.
- Block count is ceil(ad_length / rate). Example: 62 bytes at rate 16 gives positions 0, 16, 32, 48.
- DONE: done = 1 for the entry cycle only. x*_o hold until the next start. busy = 0.
- ERR: err = 1 and held. busy = 0, ad_ready = 0. Left only by start or rst.
- busy = 1 in LOAD, ISSUE and WAIT. start is ignored while busy.
- dp_sel_type, dp_data_length and dp_data are held stable from latch until the next start.
- rst mid-message: abort immediately to the reset values. Any partial word is discarded.

Optional Feature:
ASCON_AD_PERF_CNT_EN
- Defined: adds outputs blk_cnt[31:0] (blocks absorbed) and cyc_cnt[31:0] (cycles from start to done/ERR, stall cycles included). Both clear on start and rst and freeze in DONE/ERR.
- Undefined: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package ascon_pkg:
  - state enum for this block
  - rate constants RATE_128 = 8, RATE_128A = 16
  - SEL_128 / SEL_128A encodings
  - 320-bit state typedef (x0..x4)
- One sub-module, ascon_ad_wait_cnt: a down-counter that loads DP_LATENCY and flags the capture cycle. The rest stays in this block.

Test Plan:
- sel_type = 1, ad_length = 62, four words sent back-to-back -> four dp_process_en pulses at positions 0/16/32/48, dp_data_length = 62; done one cycle after the 4th capture; x*_o equal the datapath's final state.
- sel_type = 0, ad_length = 20 -> three blocks at positions 0/8/16; dp_data[127:64] = 0 on every issue.
- ad_length = 0 -> no ad_ready, no dp_process_en; done pulses; x*_o = x*_init.
- ad_valid held low 10 cycles before block 2 -> ad_ready held high, no dp_process_en during the stall; result identical to the no-stall run.
- dp_process_err forced high at block 2 capture -> err = 1, no done, busy = 0; a following start clears err and runs normally.
- rst asserted during WAIT of block 3, and start pulsed while busy -> rst returns everything to 0/IDLE; the mid-run start has no effect on position.
